dec_scan_ctrl: RTL

//  Scan sequencer that drives the select/enable inputs of a downstream 3:8 decoder.

---
 rtl/dec_scan_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dec_scan_ctrl.sv
// Scan sequencer driving a 3:8 decoder select/enable with programmable dwell.
// Optional inter-index blanking gap is enabled by defining SCAN_BLANK_EN.
module dec_scan_ctrl #(
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [2:0]       last,
    input  logic [DIV_W-1:0] div,
    output logic [2:0]       sel,
    output logic             sel_en,
    output logic             frame_done,
    output logic             busy
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_t;
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    logic [BW-1:0] r_bcnt, w_bcnt_n;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHOW} state_t;
`endif

    state_t           r_state, w_state_n;
    logic [2:0]       r_sel, w_sel_n;
    logic             r_en, w_en_n;
    logic             r_fd, w_fd_n;
    logic             r_busy, w_busy_n;
    logic [DIV_W-1:0] r_presc, w_presc_n;
    logic             r_dir, w_dir_n;
    logic [2:0]       r_last, w_last_n;
    logic [DIV_W-1:0] r_div, w_div_n;
    logic [2:0]       w_nxt;
    logic             w_wrap;

    always_comb begin
        if (r_dir) begin
            w_wrap = (r_sel == 3'd0);
            w_nxt  = w_wrap ? r_last : r_sel - 3'd1;
        end else begin
            w_wrap = (r_sel == r_last);
            w_nxt  = w_wrap ? 3'd0 : r_sel + 3'd1;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_sel_n   = r_sel;
        w_en_n    = r_en;
        w_fd_n    = 1'b0;
        w_busy_n  = r_busy;
        w_presc_n = r_presc;
        w_dir_n   = r_dir;
        w_last_n  = r_last;
        w_div_n   = r_div;
`ifdef SCAN_BLANK_EN
        w_bcnt_n  = r_bcnt;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_sel_n  = 3'd0;
                w_en_n   = 1'b0;
                w_busy_n = 1'b0;
                if (start && !stop) begin
                    w_state_n = S_SHOW;
                    w_dir_n   = dir;
                    w_last_n  = last;
                    w_div_n   = div;
                    w_sel_n   = dir ? last : 3'd0;
                    w_presc_n = '0;
                    w_en_n    = 1'b1;
                    w_busy_n  = 1'b1;
                end
            end
            S_SHOW: begin
                if (stop) begin
                    w_state_n = S_IDLE;
                    w_sel_n   = 3'd0;
                    w_en_n    = 1'b0;
                    w_busy_n  = 1'b0;
                end else if (r_presc == r_div) begin
                    w_presc_n = '0;
                    w_sel_n   = w_nxt;
                    w_fd_n    = w_wrap;
`ifdef SCAN_BLANK_EN
                    w_state_n = S_BLANK;
                    w_en_n    = 1'b0;
                    w_bcnt_n  = '0;
`endif
                end else begin
                    w_presc_n = r_presc + 1'b1;
                end
            end
`ifdef SCAN_BLANK_EN
            S_BLANK: begin
                if (stop) begin
                    w_state_n = S_IDLE;
                    w_sel_n   = 3'd0;
                    w_en_n    = 1'b0;
                    w_busy_n  = 1'b0;
                end else if (r_bcnt == BW'(BLANK_CYC - 1)) begin
                    w_state_n = S_SHOW;
                    w_en_n    = 1'b1;
                    w_presc_n = '0;
                end else begin
                    w_bcnt_n = r_bcnt + 1'b1;
                end
            end
`endif
            default: begin
                w_state_n = S_IDLE;
                w_sel_n   = 3'd0;
                w_en_n    = 1'b0;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 3'd0;
            r_en    <= 1'b0;
            r_fd    <= 1'b0;
            r_busy  <= 1'b0;
            r_presc <= '0;
            r_dir   <= 1'b0;
            r_last  <= 3'd0;
            r_div   <= '0;
`ifdef SCAN_BLANK_EN
            r_bcnt  <= '0;
`endif
        end else begin
            r_state <= w_state_n;
            r_sel   <= w_sel_n;
            r_en    <= w_en_n;
            r_fd    <= w_fd_n;
            r_busy  <= w_busy_n;
            r_presc <= w_presc_n;
            r_dir   <= w_dir_n;
            r_last  <= w_last_n;
            r_div   <= w_div_n;
`ifdef SCAN_BLANK_EN
            r_bcnt  <= w_bcnt_n;
`endif
        end
    end

    assign sel        = r_sel;
    assign sel_en     = r_en;
    assign frame_done = r_fd;
    assign busy       = r_busy;

endmodule
